// File: rtl/fu_writeback_broadcast.sv
`default_nettype none
// ============================================================================
// Module   : fu_writeback_broadcast
// Purpose  : Completion side of the issue queue. Each functional unit
//            (0=ALU0, 1=ALU1, 2=MEM) pushes results into its own small FIFO.
//            A round-robin arbiter picks one non-empty FIFO head per cycle
//            and drives it onto the registered result broadcast bus. The
//            block also keeps the per-register ready scoreboard and the
//            per-FU push-ready mask that the issue queue samples.
// Ports    : clk, rstn (sync, active low)
//            fu_valid_in/fu_rd_in/fu_result_in : per-FU result push
//            alloc_valid_in/alloc_rd_in        : new producer, clears ready bit
//            fu_ready_out                      : FU i may push this cycle
//            reg_ready_out                     : register scoreboard
//            cdb_valid/rd/value/fu_out         : registered broadcast bus
//            ovf_err_out                       : sticky dropped-push flag
//            bcast_cnt_out                     : broadcasts since reset
// Revision : 1.0 - initial release
// ============================================================================
module fu_writeback_broadcast #(
  parameter int AR_SIZE    = 7,
  parameter int AR_ARRAY   = 128,
  parameter int FU_SIZE    = 2,
  parameter int FU_ARRAY   = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [FU_ARRAY-1:0]         fu_valid_in,
  input  logic [FU_ARRAY*AR_SIZE-1:0] fu_rd_in,
  input  logic [FU_ARRAY*32-1:0]      fu_result_in,
  input  logic                        alloc_valid_in,
  input  logic [AR_SIZE-1:0]          alloc_rd_in,
  output logic [FU_ARRAY-1:0]         fu_ready_out,
  output logic [AR_ARRAY-1:0]         reg_ready_out,
  output logic                        cdb_valid_out,
  output logic [AR_SIZE-1:0]          cdb_rd_out,
  output logic [31:0]                 cdb_value_out,
  output logic [FU_SIZE-1:0]          cdb_fu_out,
  output logic                        ovf_err_out,
  output logic [15:0]                 bcast_cnt_out
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = AR_SIZE + 32;

  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [FU_SIZE-1:0] FU_LAST  = FU_SIZE'(FU_ARRAY - 1);

  // Per-FU FIFO status shared with the arbiter
  logic [FU_ARRAY-1:0] push_w;
  logic [FU_ARRAY-1:0] pop_w;
  logic [FU_ARRAY-1:0] nonempty_w;
  logic [ENT_W-1:0]    head_w [FU_ARRAY];

  // --------------------------------------------------------------------------
  // Per-FU result FIFOs. Entry = {rd, result}.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < FU_ARRAY; i++) begin : g_fifo
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Ready and empty come from the registered count only, so a pop in the
    // same cycle never raises ready and a fresh push is never granted
    // before it has been stored.
    assign fu_ready_out[i] = (count_q < CNT_FULL);
    assign nonempty_w[i]   = (count_q != '0);
    assign push_w[i]       = fu_valid_in[i] && fu_ready_out[i];
    assign head_w[i]       = mem_q[rd_ptr_q];

    always_comb begin
      count_d = count_q;
      if (push_w[i] && !pop_w[i]) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_w[i] && pop_w[i]) begin
        count_d = count_q - CNT_W'(1);
      end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
      if (push_w[i]) begin
        mem_q[wr_ptr_q] <= {fu_rd_in[i*AR_SIZE +: AR_SIZE], fu_result_in[i*32 +: 32]};
      end
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        count_q <= count_d;
        if (push_w[i]) begin
          wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_w[i]) begin
          rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin arbitration over non-empty heads, starting at rr_ptr_q
  // --------------------------------------------------------------------------
  logic               grant_w;
  logic [FU_SIZE-1:0] grant_fu_w;
  logic [ENT_W-1:0]   grant_ent_w;
  logic [AR_SIZE-1:0] grant_rd_w;
  logic [31:0]        grant_val_w;
  logic [FU_SIZE-1:0] rr_ptr_q;
  logic [FU_SIZE-1:0] rr_ptr_d;
  int                 cand_w;

  always_comb begin
    grant_w    = 1'b0;
    grant_fu_w = '0;
    cand_w     = 0;
    for (int k = 0; k < FU_ARRAY; k++) begin
      cand_w = int'(rr_ptr_q) + k;
      if (cand_w >= FU_ARRAY) begin
        cand_w = cand_w - FU_ARRAY;
      end
      if (!grant_w && nonempty_w[FU_SIZE'(cand_w)]) begin
        grant_w    = 1'b1;
        grant_fu_w = FU_SIZE'(cand_w);
      end
    end
  end

  always_comb begin
    pop_w = '0;
    for (int i = 0; i < FU_ARRAY; i++) begin
      pop_w[i] = grant_w && (grant_fu_w == FU_SIZE'(i));
    end
  end

  assign grant_ent_w = head_w[grant_fu_w];
  assign grant_rd_w  = grant_ent_w[ENT_W-1 -: AR_SIZE];
  assign grant_val_w = grant_ent_w[31:0];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_w) begin
      rr_ptr_d = (grant_fu_w == FU_LAST) ? '0 : grant_fu_w + FU_SIZE'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard: grant sets, alloc clears afterwards so the newer producer
  // wins on a collision; register 0 is hard-wired ready.
  // --------------------------------------------------------------------------
  logic [AR_ARRAY-1:0] reg_ready_q;
  logic [AR_ARRAY-1:0] reg_ready_d;

  always_comb begin
    reg_ready_d = reg_ready_q;
    if (grant_w) begin
      reg_ready_d[grant_rd_w] = 1'b1;
    end
    if (alloc_valid_in) begin
      reg_ready_d[alloc_rd_in] = 1'b0;
    end
    reg_ready_d[0] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Broadcast bus, error flag and counter
  // --------------------------------------------------------------------------
  logic               cdb_valid_q;
  logic [AR_SIZE-1:0] cdb_rd_q;
  logic [31:0]        cdb_value_q;
  logic [FU_SIZE-1:0] cdb_fu_q;
  logic               ovf_err_q;
  logic [15:0]        bcast_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_q    <= '0;
      reg_ready_q <= '1;
      cdb_valid_q <= 1'b0;
      cdb_rd_q    <= '0;
      cdb_value_q <= '0;
      cdb_fu_q    <= '0;
      ovf_err_q   <= 1'b0;
      bcast_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      reg_ready_q <= reg_ready_d;
      cdb_valid_q <= grant_w;
      if (grant_w) begin
        cdb_rd_q    <= grant_rd_w;
        cdb_value_q <= grant_val_w;
        cdb_fu_q    <= grant_fu_w;
        bcast_cnt_q <= bcast_cnt_q + 16'd1;
      end
      // A push offered while the FIFO is full is lost; remember it.
      if (|(fu_valid_in & ~fu_ready_out)) begin
        ovf_err_q <= 1'b1;
      end
    end
  end

  assign reg_ready_out = reg_ready_q;
  assign cdb_valid_out = cdb_valid_q;
  assign cdb_rd_out    = cdb_rd_q;
  assign cdb_value_out = cdb_value_q;
  assign cdb_fu_out    = cdb_fu_q;
  assign ovf_err_out   = ovf_err_q;
  assign bcast_cnt_out = bcast_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fu_writeback_broadcast.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_writeback_broadcast
// Purpose  : Self-checking bench for fu_writeback_broadcast. A queue-based
//            reference model predicts every output after each clock edge;
//            directed scenarios are followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fu_writeback_broadcast;

  localparam int AR_SIZE  = 7;
  localparam int AR_ARRAY = 128;
  localparam int FU_SIZE  = 2;
  localparam int FU_ARRAY = 3;
  localparam int DEPTH    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rstn;
  logic [FU_ARRAY-1:0]         fu_valid_in;
  logic [FU_ARRAY*AR_SIZE-1:0] fu_rd_in;
  logic [FU_ARRAY*32-1:0]      fu_result_in;
  logic                        alloc_valid_in;
  logic [AR_SIZE-1:0]          alloc_rd_in;
  logic [FU_ARRAY-1:0]         fu_ready_out;
  logic [AR_ARRAY-1:0]         reg_ready_out;
  logic                        cdb_valid_out;
  logic [AR_SIZE-1:0]          cdb_rd_out;
  logic [31:0]                 cdb_value_out;
  logic [FU_SIZE-1:0]          cdb_fu_out;
  logic                        ovf_err_out;
  logic [15:0]                 bcast_cnt_out;

  fu_writeback_broadcast #(
    .AR_SIZE   (AR_SIZE),
    .AR_ARRAY  (AR_ARRAY),
    .FU_SIZE   (FU_SIZE),
    .FU_ARRAY  (FU_ARRAY),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .fu_valid_in   (fu_valid_in),
    .fu_rd_in      (fu_rd_in),
    .fu_result_in  (fu_result_in),
    .alloc_valid_in(alloc_valid_in),
    .alloc_rd_in   (alloc_rd_in),
    .fu_ready_out  (fu_ready_out),
    .reg_ready_out (reg_ready_out),
    .cdb_valid_out (cdb_valid_out),
    .cdb_rd_out    (cdb_rd_out),
    .cdb_value_out (cdb_value_out),
    .cdb_fu_out    (cdb_fu_out),
    .ovf_err_out   (ovf_err_out),
    .bcast_cnt_out (bcast_cnt_out)
  );

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [AR_SIZE-1:0] rd;
    logic [31:0]        val;
  } ent_t;

  ent_t          mq [FU_ARRAY][$];
  int            m_rr;
  logic [127:0]  m_sb;
  logic          m_cv;
  logic [6:0]    m_crd;
  logic [31:0]   m_cval;
  logic [1:0]    m_cfu;
  logic          m_ovf;
  logic [15:0]   m_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < FU_ARRAY; i++) mq[i].delete();
    m_rr   = 0;
    m_sb   = '1;
    m_cv   = 1'b0;
    m_crd  = '0;
    m_cval = '0;
    m_cfu  = '0;
    m_ovf  = 1'b0;
    m_cnt  = '0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [FU_ARRAY-1:0] rdy;
    int   w;
    ent_t e;
    ent_t n;
    if (!rstn) begin
      model_reset();
      return;
    end
    for (int i = 0; i < FU_ARRAY; i++) rdy[i] = (mq[i].size() < DEPTH);
    w = -1;
    for (int k = 0; k < FU_ARRAY; k++) begin
      int c = (m_rr + k) % FU_ARRAY;
      if (w < 0 && mq[c].size() > 0) w = c;
    end
    if (w >= 0) begin
      e      = mq[w].pop_front();
      m_cv   = 1'b1;
      m_crd  = e.rd;
      m_cval = e.val;
      m_cfu  = 2'(w);
      m_rr   = (w + 1) % FU_ARRAY;
      m_cnt  = m_cnt + 16'd1;
      m_sb[e.rd] = 1'b1;
    end else begin
      m_cv = 1'b0;
    end
    if (alloc_valid_in) m_sb[alloc_rd_in] = 1'b0;
    m_sb[0] = 1'b1;
    for (int i = 0; i < FU_ARRAY; i++) begin
      if (fu_valid_in[i]) begin
        if (rdy[i]) begin
          n.rd  = fu_rd_in[i*AR_SIZE +: AR_SIZE];
          n.val = fu_result_in[i*32 +: 32];
          mq[i].push_back(n);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [FU_ARRAY-1:0] m_ready;
    for (int i = 0; i < FU_ARRAY; i++) m_ready[i] = (mq[i].size() < DEPTH);
    check_eq("fu_ready",  fu_ready_out,  m_ready);
    check_eq("reg_ready", reg_ready_out, m_sb);
    check_eq("cdb_valid", cdb_valid_out, m_cv);
    check_eq("cdb_rd",    cdb_rd_out,    m_crd);
    check_eq("cdb_value", cdb_value_out, m_cval);
    check_eq("cdb_fu",    cdb_fu_out,    m_cfu);
    check_eq("ovf_err",   ovf_err_out,   m_ovf);
    check_eq("bcast_cnt", bcast_cnt_out, m_cnt);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_idle();
    rstn           = 1'b1;
    fu_valid_in    = '0;
    alloc_valid_in = 1'b0;
  endtask

  task automatic push(input int fu, input logic [6:0] rd, input logic [31:0] v);
    fu_valid_in[fu]            = 1'b1;
    fu_rd_in[fu*AR_SIZE +: 7]  = rd;
    fu_result_in[fu*32 +: 32]  = v;
  endtask

  task automatic do_reset();
    set_idle();
    rstn = 1'b0;
    tick();
    set_idle();
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    rstn           = 1'b0;
    fu_valid_in    = '0;
    fu_rd_in       = '0;
    fu_result_in   = '0;
    alloc_valid_in = 1'b0;
    alloc_rd_in    = '0;
    model_reset();
    tick();
    tick();
    set_idle();
    tick();
    tick();
    check_eq("rst_reg_ready", reg_ready_out, {128{1'b1}});
    check_eq("rst_fu_ready",  fu_ready_out,  3'b111);
    check_eq("rst_cdb_valid", cdb_valid_out, 0);
    check_eq("rst_bcast_cnt", bcast_cnt_out, 0);

    // Allocate rd 5, then FU0 completes it
    alloc_valid_in = 1'b1;
    alloc_rd_in    = 7'd5;
    tick();
    set_idle();
    check_eq("alloc5_clear", reg_ready_out[5], 0);
    push(0, 7'd5, 32'hDEADBEEF);
    tick();
    set_idle();
    check_eq("push5_pending", reg_ready_out[5], 0);
    check_eq("push5_no_bcast", cdb_valid_out, 0);
    tick();
    check_eq("b5_valid", cdb_valid_out, 1);
    check_eq("b5_rd",    cdb_rd_out,    5);
    check_eq("b5_value", cdb_value_out, 32'hDEADBEEF);
    check_eq("b5_fu",    cdb_fu_out,    0);
    check_eq("b5_ready", reg_ready_out[5], 1);

    // All three FUs push together from rr_ptr = 0
    do_reset();
    push(0, 7'd1, 32'h1111_0000);
    push(1, 7'd2, 32'h2222_0000);
    push(2, 7'd3, 32'h3333_0000);
    tick();
    set_idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("rr_valid", cdb_valid_out, 1);
      check_eq("rr_order", cdb_fu_out, k);
    end
    check_eq("rr_cnt3", bcast_cnt_out, 3);
    push(1, 7'd4, 32'h4444_0000);
    push(2, 7'd6, 32'h6666_0000);
    push(0, 7'd7, 32'h7777_0000);
    tick();
    set_idle();
    tick();
    check_eq("rr_wrapped_fu0", cdb_fu_out, 0);
    tick();
    tick();
    tick();

    // FU2 overflow while ALU traffic takes the grants
    do_reset();
    push(0, 7'd10, 32'hA0A0_0001);
    push(1, 7'd11, 32'hA1A1_0001);
    push(2, 7'd12, 32'hC1C1C1C1);
    tick();
    set_idle();
    push(0, 7'd13, 32'hA0A0_0002);
    push(2, 7'd14, 32'hC2C2C2C2);
    tick();
    set_idle();
    check_eq("fu2_full", fu_ready_out[2], 0);
    check_eq("ovf_before", ovf_err_out, 0);
    push(1, 7'd15, 32'hA1A1_0002);
    push(2, 7'd16, 32'hC3C3C3C3);
    tick();
    set_idle();
    check_eq("ovf_set", ovf_err_out, 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("dropped_never_bcast", (cdb_valid_out && cdb_value_out == 32'hC3C3C3C3), 0);
    end
    check_eq("fu2_ready_again", fu_ready_out[2], 1);
    check_eq("ovf_sticky", ovf_err_out, 1);

    // Alloc and grant of the same register in one cycle: clear wins
    push(0, 7'd9, 32'h0909_0909);
    tick();
    set_idle();
    alloc_valid_in = 1'b1;
    alloc_rd_in    = 7'd9;
    tick();
    set_idle();
    check_eq("coll_bcast_rd", cdb_rd_out, 9);
    check_eq("coll_bit9", reg_ready_out[9], 0);
    alloc_valid_in = 1'b1;
    alloc_rd_in    = 7'd0;
    tick();
    set_idle();
    check_eq("alloc0_ignored", reg_ready_out[0], 1);

    // Reset with results buffered
    push(0, 7'd20, 32'h2020_2020);
    push(1, 7'd21, 32'h2121_2121);
    tick();
    set_idle();
    rstn = 1'b0;
    tick();
    set_idle();
    check_eq("midrst_cnt", bcast_cnt_out, 0);
    check_eq("midrst_ovf", ovf_err_out, 0);
    check_eq("midrst_fu_ready", fu_ready_out, 3'b111);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("midrst_no_bcast", cdb_valid_out, 0);
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rstn = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < FU_ARRAY; i++) begin
        fu_valid_in[i]               = ($urandom_range(0, 99) < 45);
        fu_rd_in[i*AR_SIZE +: 7]     = 7'($urandom);
        fu_result_in[i*32 +: 32]     = $urandom;
      end
      alloc_valid_in = ($urandom_range(0, 3) == 0);
      alloc_rd_in    = 7'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
